if_stage_iq: RTL
================

Name: if_stage_iq

Overview:
Parametrised fetch stage for the 5-stage LoongArch core. Owns the PC and issues requests on a split request/response inst SRAM-like bus. Returned instructions are buffered in an instruction queue of depth IQ_DEPTH, which decouples fetch from ID stalls. Branch redirects flush the queue and discard in-flight responses so that no wrong-path instruction reaches ID.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset
IQ_DEPTH, 4, instruction-queue entries and max in-flight requests; power of 2, >=2
BR_BUS_W, 34, width of br_bus, laid out as {br_taken, br_stall, br_target[31:0]}

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, asynchronous, active-high
id_allowin  in  1  ID can accept this cycle
if_validout  out  1  if_to_id_bus holds a valid instruction
if_to_id_bus  out  64  {pc[31:0], inst[31:0]} of the queue head
br_bus  in  BR_BUS_W  from ID: br_taken (1-cycle redirect pulse), br_stall (branch unresolved, hold fetch), br_target
inst_sram_req  out  1  request valid
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'd2 (word)
inst_sram_wstrb  out  4  constant 0
inst_sram_addr  out  32  {fpc[31:2], 2'b00}
inst_sram_wdata  out  32  constant 0
inst_sram_addr_ok  in  1  request accepted this cycle (handshake = req & addr_ok)
inst_sram_data_ok  in  1  in-order response valid
inst_sram_rdata  in  32  response data

Behaviour:
- State: fpc; pend_pc FIFO (IQ_DEPTH entries, PC per accepted request); iq FIFO (IQ_DEPTH entries of {pc,inst}); outstanding count and discard count, each $clog2(IQ_DEPTH)+1 bits.
- Reset (async): fpc=RESET_PC; all pointers, counts and discard=0; if_validout=0; inst_sram_req=0.
- inst_sram_req = ~br_taken & ~br_stall & (outstanding + iq_count < IQ_DEPTH). This is combinational from br_bus. Once raised, req and addr stay stable until addr_ok, unless br_taken or br_stall drops it.
- Handshake: fpc <= fpc+4 (wraps modulo 2^32); push fpc into pend_pc; outstanding+1.
- data_ok: pop pend_pc; outstanding-1. If discard>0, drop the response and decrement discard. Otherwise push {pc, rdata} into iq.
- data_ok while outstanding==0 (stray after reset) is ignored, with no counter underflow.
- Output: if_validout = (iq_count != 0); if_to_id_bus = iq head. Pop when if_validout & id_allowin. Push and pop in the same cycle keep iq_count unchanged.
- Min latency: handshake in cycle N, data_ok in N+1, if_validout in N+2.
- Redirect (br_taken=1):
  - fpc <= br_target (low 2 bits ignored for addressing).
  - iq flushed: count=0, if_validout=0 next cycle, no pop this cycle.
  - discard <= outstanding minus (1 if data_ok this cycle). A data_ok in the redirect cycle is always dropped.
  - No handshake can occur in the redirect cycle because req is gated.
- br_stall=1: no new requests. In-flight responses still complete and are queued; iq still drains.
- br_taken and br_stall both high: redirect applies; req stays low.
- Credit rule guarantees iq never overflows and pend_pc never overflows. Full iq with id_allowin=0 leaves req low.
- Back-to-back redirects: discard recomputed each time from the current outstanding; already-discarding entries stay counted.

Test Plan:
- Reset release, addr_ok=1, data_ok 1 cycle after each handshake, id_allowin=1 -> addr sequence 0x1c000000, 0x1c000004, ...; first if_validout 2 cycles after first handshake with pc=0x1c000000.
- id_allowin=0 for 10 cycles with IQ_DEPTH=4 -> exactly 4 handshakes, iq full, req low; on release, pcs emerge in order with no gap or duplicate.
- 3 requests in flight, br_taken with target 0x1c000100 -> next 3 data_ok dropped; next valid output pc=0x1c000100 with its rdata.
- br_taken in the same cycle as data_ok, 2 outstanding -> that response and 1 more dropped; discard returns to 0.
- br_stall held 5 cycles with 2 outstanding -> no handshakes; both responses queued; fetch resumes at the unchanged fpc after the stall clears.
- Async rst asserted mid-stream with 2 outstanding, then stray data_ok after release -> outputs 0 immediately; stray responses ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_iq.sv
// Fetch stage: owns the PC, issues split-transaction inst SRAM requests and
// buffers returned instructions in a queue that decouples fetch from ID.
module if_stage_iq #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int unsigned IQ_DEPTH = 4,
    parameter int unsigned BR_BUS_W = 34
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_allowin,
    output logic                if_validout,
    output logic [63:0]         if_to_id_bus,
    input  logic [BR_BUS_W-1:0] br_bus,
    output logic                inst_sram_req,
    output logic                inst_sram_wr,
    output logic [1:0]          inst_sram_size,
    output logic [3:0]          inst_sram_wstrb,
    output logic [31:0]         inst_sram_addr,
    output logic [31:0]         inst_sram_wdata,
    input  logic                inst_sram_addr_ok,
    input  logic                inst_sram_data_ok,
    input  logic [31:0]         inst_sram_rdata
);

    localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic        br_taken;
    logic        br_stall;
    logic [31:0] br_target;

    assign br_taken  = br_bus[33];
    assign br_stall  = br_bus[32];
    assign br_target = br_bus[31:0];

    logic [31:0]      fpc_q, fpc_d;
    logic [PTR_W-1:0] pend_wr_q, pend_wr_d;
    logic [PTR_W-1:0] pend_rd_q, pend_rd_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [PTR_W-1:0] iq_wr_q, iq_wr_d;
    logic [PTR_W-1:0] iq_rd_q, iq_rd_d;
    logic [CNT_W-1:0] iq_cnt_q, iq_cnt_d;

    logic [31:0] pend_pc_mem [IQ_DEPTH];
    logic [63:0] iq_mem      [IQ_DEPTH];

    logic credit_c;
    logic req_c;
    logic hs_c;
    logic rsp_c;
    logic drop_c;
    logic iq_push_c;
    logic iq_pop_c;

    // Credits cover both in-flight requests and queued instructions, so
    // neither FIFO can overflow.
    always_comb begin
        credit_c  = (SUM_W'(outstanding_q) + SUM_W'(iq_cnt_q)) < SUM_W'(IQ_DEPTH);
        req_c     = ~rst & ~br_taken & ~br_stall & credit_c;
        hs_c      = req_c & inst_sram_addr_ok;
        rsp_c     = inst_sram_data_ok & (outstanding_q != '0);
        drop_c    = rsp_c & (br_taken | (discard_q != '0));
        iq_push_c = rsp_c & ~drop_c;
        iq_pop_c  = if_validout & id_allowin & ~br_taken;
    end

    always_comb begin
        fpc_d         = fpc_q;
        pend_wr_d     = pend_wr_q;
        pend_rd_d     = pend_rd_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        iq_wr_d       = iq_wr_q;
        iq_rd_d       = iq_rd_q;
        iq_cnt_d      = iq_cnt_q;

        if (br_taken) begin
            fpc_d = br_target;
        end else if (hs_c) begin
            fpc_d = fpc_q + 32'd4;
        end

        if (hs_c) begin
            pend_wr_d = pend_wr_q + PTR_W'(1);
        end
        if (rsp_c) begin
            pend_rd_d = pend_rd_q + PTR_W'(1);
        end
        outstanding_d = outstanding_q + CNT_W'(hs_c) - CNT_W'(rsp_c);

        // Every request still in flight after a redirect is wrong-path.
        if (br_taken) begin
            discard_d = outstanding_q - CNT_W'(rsp_c);
        end else if (rsp_c && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        if (br_taken) begin
            iq_rd_d  = iq_wr_q;
            iq_cnt_d = '0;
        end else begin
            if (iq_push_c) begin
                iq_wr_d = iq_wr_q + PTR_W'(1);
            end
            if (iq_pop_c) begin
                iq_rd_d = iq_rd_q + PTR_W'(1);
            end
            iq_cnt_d = iq_cnt_q + CNT_W'(iq_push_c) - CNT_W'(iq_pop_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            pend_wr_q     <= '0;
            pend_rd_q     <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            iq_wr_q       <= '0;
            iq_rd_q       <= '0;
            iq_cnt_q      <= '0;
        end else begin
            fpc_q         <= fpc_d;
            pend_wr_q     <= pend_wr_d;
            pend_rd_q     <= pend_rd_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            iq_wr_q       <= iq_wr_d;
            iq_rd_q       <= iq_rd_d;
            iq_cnt_q      <= iq_cnt_d;
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (hs_c) begin
            pend_pc_mem[pend_wr_q] <= fpc_q;
        end
        if (iq_push_c) begin
            iq_mem[iq_wr_q] <= {pend_pc_mem[pend_rd_q], inst_sram_rdata};
        end
    end

    assign if_validout     = (iq_cnt_q != '0);
    assign if_to_id_bus    = iq_mem[iq_rd_q];

    assign inst_sram_req   = req_c;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_addr  = {fpc_q[31:2], 2'b00};
    assign inst_sram_wdata = 32'd0;

    a_out_bound: assert property (@(posedge clk) disable iff (rst)
        outstanding_q <= CNT_W'(IQ_DEPTH));
    a_iq_bound: assert property (@(posedge clk) disable iff (rst)
        iq_cnt_q <= CNT_W'(IQ_DEPTH));
    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        discard_q <= outstanding_q);

endmodule
